// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: one bit pair per accepted cycle, registered one-hot g/l/e with a done pulse.
// Build option: define SERIAL_MAG_COMPARATOR_LSB_FIRST_EN for LSB-first operand delivery (default is MSB first).
module serial_mag_comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic start_in,
    input  logic bit_valid_in,
    input  logic a_bit_in,
    input  logic b_bit_in,
    output logic busy_out,
    output logic done_out,
    output logic g_out,
    output logic l_out,
    output logic e_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             gt_q;
    logic             lt_q;
    logic             gt_d;
    logic             lt_d;
    logic             busy_q;
    logic             done_q;
    logic             g_q;
    logic             l_q;
    logic             e_q;

    // Decision update for the current bit pair; gt=lt=0 encodes "equal so far".
    always_comb begin
        gt_d = gt_q;
        lt_d = lt_q;
`ifdef SERIAL_MAG_COMPARATOR_LSB_FIRST_EN
        if (a_bit_in != b_bit_in) begin
            gt_d = a_bit_in;
            lt_d = b_bit_in;
        end
`else
        if (!gt_q && !lt_q && (a_bit_in != b_bit_in)) begin
            gt_d = a_bit_in;
            lt_d = b_bit_in;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_in) begin
                        state_q <= COMPARE;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                COMPARE: begin
                    if (bit_valid_in) begin
                        gt_q  <= gt_d;
                        lt_q  <= lt_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        // Last pair: publish the decision including this pair.
                        if (cnt_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            g_q     <= gt_d;
                            l_q     <= lt_d;
                            e_q     <= !(gt_d || lt_d);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_out = busy_q;
    assign done_out = done_q;
    assign g_out    = g_q;
    assign l_out    = l_q;
    assign e_out    = e_q;

endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Bit-serial magnitude comparator for two WIDTH-bit unsigned operands delivered one bit pair per accepted cycle, MSB first by default. It extends the team's 1-bit greater/less/equal comparator cell across multi-bit words over time. It lets serial links and shift-register datapaths compare words without parallelising them. It returns a registered one-hot greater/less/equal result with a done pulse.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range WIDTH >= 1.

Ports:
- clk_in  input  1  single clock; all state updates on the rising edge.
- rst_n_in  input  1  synchronous, active-low reset.
- start_in  input  1  begin a new comparison; honoured only in IDLE or DONE.
- bit_valid_in  input  1  a_bit_in/b_bit_in carry a valid bit pair this cycle.
- a_bit_in  input  1  current bit of operand A.
- b_bit_in  input  1  current bit of operand B.
- busy_out  output  1  high while in COMPARE.
- done_out  output  1  one-cycle pulse when the result is published.
- g_out  output  1  A > B.
- l_out  output  1  A < B.
- e_out  output  1  A == B.

## Operation
- Clocking: one clock, clk_in. Reset: synchronous, active-low, rst_n_in.
- FSM states: IDLE, COMPARE, DONE.
- IDLE: start_in=1 moves to COMPARE. Bit counter is cleared. Internal decision is set to "equal, undecided".
- COMPARE: each cycle with bit_valid_in=1 consumes one bit pair and increments the counter. Cycles with bit_valid_in=0 are stalls, and no state changes.
- Decision rule (MSB first): the first pair with a_bit_in != b_bit_in decides the result. A=1,B=0 means greater; A=0,B=1 means less. Later pairs are still consumed but do not change the decision.
- When the WIDTH-th pair is consumed, move to DONE. g_out/l_out/e_out load the decision, exactly one high. done_out=1 for that single cycle.
- DONE lasts one cycle. Next state is COMPARE if start_in=1, otherwise IDLE.
- Result outputs hold their value until the next DONE or reset. They do not change during COMPARE.
- Counter width is $clog2(WIDTH+1). WIDTH=1 reduces the block to a registered single-cell compare.

Boundary rules:
- start_in in COMPARE is ignored. The current comparison is not restarted.
- start_in and bit_valid_in high in the same IDLE cycle: the bit is ignored. The first bit is sampled no earlier than the cycle after start is accepted.
- bit_valid_in in IDLE or DONE is ignored.
- Reset (any state, including mid-COMPARE) returns the FSM to IDLE. All outputs go to 0 and the partial decision is discarded.

## Timing
Reset values: busy_out=0, done_out=0, g_out=0, l_out=0, e_out=0. All-zero result means "no result yet".

Cycle sequence:
- start_in is sampled on edge 0.
- busy_out=1 from the cycle after edge 0.
- With bit_valid_in continuously high, bits are sampled on edges 1..WIDTH.
- done_out and the result are visible in the cycle after edge WIDTH, so latency is WIDTH+1 cycles from start.
- Each stall cycle adds one cycle of latency.
- busy_out drops in the same cycle done_out rises.

Back-to-back use: start_in held high during DONE gives zero idle cycles between comparisons.

All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- SERIAL_MAG_COMPARATOR_LSB_FIRST_EN.
- Defined: bits arrive LSB first. Every differing pair overwrites the decision, so the last differing pair wins. Equal pairs leave it unchanged.
- Undefined: MSB-first, first-difference-wins behaviour as described above.
- FSM, handshake and timing are identical in both builds.

## Test plan
- Reset then idle: all outputs 0. WIDTH=8, A=0xA5, B=0xA5, bits every cycle -> done_out pulse at cycle 9 with e_out=1, g_out=l_out=0.
- A=0x80, B=0x7F, MSB first -> g_out=1 (decided at bit 7). A=0x3C, B=0x3D -> l_out=1. Results hold until the next start.
- Gapped input: A=0x12, B=0x21 with bit_valid_in low on alternate cycles -> l_out=1. done_out comes one cycle after the 8th valid bit. busy_out stays high throughout.
- start_in pulsed mid-COMPARE -> ignored; the original comparison completes. start_in held in the DONE cycle -> the next comparison begins with zero idle cycles.
- rst_n_in=0 after 4 bits -> next cycle IDLE with all outputs 0. A fresh A=0x01, B=0x00 -> g_out=1.
- With SERIAL_MAG_COMPARATOR_LSB_FIRST_EN defined: A=0x01, B=0x02 sent LSB first -> l_out=1. A=0xF0, B=0x0F -> g_out=1.
